// File: rtl/shift_left_seq_if.sv
// Request/response bundle for the digit-granular left shifter.
// master drives requests and accepts results; slave is the shifter.
interface shift_left_seq_if #(
    parameter int DIGIT_W = 5,
    parameter int DIGITS  = 10,
    parameter int SHIFT_W = 3
);
    localparam int W = DIGITS * DIGIT_W;

    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in_data;
    logic [SHIFT_W-1:0] in_shift;
    logic [DIGIT_W-1:0] in_fill;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_data;
    logic               out_err;

    modport master (
        output in_valid, in_data, in_shift, in_fill, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, in_shift, in_fill, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/shift_left_seq.sv
// Sequential left shifter: moves a word left by 0..MAX_SHIFT digits, one digit per clock.
// Define SHIFT_LEFT_ONE_CYCLE_EN to apply the whole shift at acceptance instead.
//
//   state | meaning
//   IDLE  | waiting for a request, in_ready=1
//   SHIFT | shifting one digit per clock (absent with SHIFT_LEFT_ONE_CYCLE_EN)
//   DONE  | result presented, waiting for out_ready
module shift_left_seq #(
    parameter int DIGIT_W   = 5,
    parameter int DIGITS    = 10,
    parameter int SHIFT_W   = 3,
    parameter int MAX_SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    shift_left_seq_if.slave  bus
);
    localparam int W = DIGITS * DIGIT_W;

`ifdef SHIFT_LEFT_ONE_CYCLE_EN
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t       state_q, state_d;
    logic [W-1:0] data_q, data_d;
    logic         err_q, err_d;
    logic         accept;
    logic         shift_zero;
    logic         shift_bad;

`ifdef SHIFT_LEFT_ONE_CYCLE_EN
    logic [W-1:0] shifted;

    always_comb begin
        shifted = bus.in_data << (DIGIT_W * int'(bus.in_shift));
        for (int i = 0; i < DIGITS; i++) begin
            if (i < int'(bus.in_shift)) begin
                shifted[i*DIGIT_W +: DIGIT_W] = bus.in_fill;
            end
        end
    end
`else
    logic [DIGIT_W-1:0] fill_q, fill_d;
    logic [SHIFT_W-1:0] cnt_q, cnt_d;
`endif

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = data_q;
    assign bus.out_err   = err_q;

    assign accept     = bus.in_valid && bus.in_ready;
    assign shift_zero = (bus.in_shift == '0);
    assign shift_bad  = (int'(bus.in_shift) > MAX_SHIFT);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        err_d   = err_q;
`ifndef SHIFT_LEFT_ONE_CYCLE_EN
        fill_d  = fill_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifndef SHIFT_LEFT_ONE_CYCLE_EN
                    fill_d = bus.in_fill;
                    cnt_d  = bus.in_shift;
`endif
                    if (shift_bad) begin
                        // illegal amount: no steps, word becomes all fill digits
                        data_d  = {DIGITS{bus.in_fill}};
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (shift_zero) begin
                        data_d  = bus.in_data;
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
`ifdef SHIFT_LEFT_ONE_CYCLE_EN
                        data_d  = shifted;
                        state_d = DONE;
`else
                        data_d  = bus.in_data;
                        state_d = SHIFT;
`endif
                    end
                end
            end
`ifndef SHIFT_LEFT_ONE_CYCLE_EN
            SHIFT: begin
                data_d = {data_q[W-DIGIT_W-1:0], fill_q};
                cnt_d  = cnt_q - SHIFT_W'(1);
                if (cnt_q == SHIFT_W'(1)) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifndef SHIFT_LEFT_ONE_CYCLE_EN
            fill_q  <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifndef SHIFT_LEFT_ONE_CYCLE_EN
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
`endif
        end
    end
endmodule
